// File: rtl/motor_speed_controller.sv
// Closed-loop PI motor speed controller with glitch-free PWM output.
// A periodic tick launches a five-stage PI update; duty reloads only at PWM wrap.
module motor_speed_controller #(
  parameter int unsigned SAMPLE_CYCLES = 12_500_000,
  parameter logic [15:0] KP            = 16'd4,
  parameter logic [15:0] KI            = 16'd1,
  parameter int unsigned SHIFT         = 4,
  parameter int          INT_LIMIT     = 1_048_576
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        enable_in,
  input  logic [20:0] target_rpm_in,
  input  logic [20:0] actual_rpm_in,
  output logic [9:0]  duty_out,
  output logic        pwm_out,
  output logic        update_done_out
);

  localparam int CW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_CYCLES - 1);
  localparam logic signed [31:0] LIM  = 32'(INT_LIMIT);
  localparam logic signed [31:0] NLIM = -LIM;

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_INTEG, S_MULT, S_SUM, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       samp_q, samp_d;
  logic signed [21:0]  err_q, err_d;
  logic signed [31:0]  integ_q, integ_d;
  logic signed [47:0]  p_q, p_d;
  logic signed [47:0]  i_q, i_d;
  logic [9:0]          duty_q, duty_d;
  logic [9:0]          pwm_cnt_q, pwm_cnt_d;
  logic [9:0]          act_q, act_d;

  logic                tick;
  logic signed [31:0]  integ_sum;
  logic signed [48:0]  sum;
  logic signed [48:0]  u_sh;
  logic [9:0]          u_sat;

  // Sample counter: free-running, independent of enable.
  always_comb begin
    tick   = (samp_q == LAST);
    samp_d = tick ? '0 : samp_q + 1'b1;
  end

  // Arithmetic helpers: integrator clamp and output saturation.
  always_comb begin
    integ_sum = integ_q + $signed({{10{err_q[21]}}, err_q});
    sum       = $signed({p_q[47], p_q}) + $signed({i_q[47], i_q});
    u_sh      = sum >>> SHIFT;
    if (u_sh[48])
      u_sat = 10'd0;
    else if (u_sh > 49'sd1023)
      u_sat = 10'd1023;
    else
      u_sat = u_sh[9:0];
  end

  // Next-state and datapath: one pipeline step per state.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    integ_d = integ_q;
    p_d     = p_q;
    i_d     = i_q;
    duty_d  = duty_q;
    unique case (state_q)
      S_IDLE:  if (tick) state_d = S_LATCH;
      S_LATCH: begin
        err_d   = $signed({1'b0, target_rpm_in}) - $signed({1'b0, actual_rpm_in});
        state_d = S_INTEG;
      end
      S_INTEG: begin
        if (integ_sum > LIM)
          integ_d = LIM;
        else if (integ_sum < NLIM)
          integ_d = NLIM;
        else
          integ_d = integ_sum;
        state_d = S_MULT;
      end
      S_MULT: begin
        p_d = $signed({32'd0, KP}) * $signed({{26{err_q[21]}}, err_q});
        i_d = $signed({32'd0, KI}) * $signed({{16{integ_q[31]}}, integ_q});
        state_d = S_SUM;
      end
      // duty is registered on entry to DONE so it is valid alongside the strobe
      S_SUM: begin
        duty_d  = u_sat;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (!enable_in) begin
      state_d = S_IDLE;
      integ_d = '0;
      duty_d  = '0;
    end
  end

  // PWM counter and active duty, reloaded only at period wrap.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 10'd1;
    act_d     = (pwm_cnt_q == 10'd1023) ? duty_q : act_q;
    if (!enable_in) act_d = '0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q   <= S_IDLE;
      samp_q    <= '0;
      err_q     <= '0;
      integ_q   <= '0;
      p_q       <= '0;
      i_q       <= '0;
      duty_q    <= '0;
      pwm_cnt_q <= '0;
      act_q     <= '0;
    end else begin
      state_q   <= state_d;
      samp_q    <= samp_d;
      err_q     <= err_d;
      integ_q   <= integ_d;
      p_q       <= p_d;
      i_q       <= i_d;
      duty_q    <= duty_d;
      pwm_cnt_q <= pwm_cnt_d;
      act_q     <= act_d;
    end
  end

  assign duty_out        = duty_q;
  assign pwm_out         = enable_in && (pwm_cnt_q < act_q);
  assign update_done_out = enable_in && (state_q == S_DONE);

endmodule

// File: tb/tb_motor_speed_controller.sv
// Scoreboard bench for motor_speed_controller.
// Stimulus queues expected duties and PWM high-times; a monitor pops and compares.
module tb_motor_speed_controller;

  localparam int SC = 1000;

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b1;
  logic        enable_in = 1'b0;
  logic [20:0] target_rpm_in = '0;
  logic [20:0] actual_rpm_in = '0;
  logic [9:0]  duty_out;
  logic        pwm_out;
  logic        update_done_out;

  motor_speed_controller #(.SAMPLE_CYCLES(SC)) dut (
    .clk_in          (clk_in),
    .reset_in        (reset_in),
    .enable_in       (enable_in),
    .target_rpm_in   (target_rpm_in),
    .actual_rpm_in   (actual_rpm_in),
    .duty_out        (duty_out),
    .pwm_out         (pwm_out),
    .update_done_out (update_done_out)
  );

  always #4 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int per;
    int highs;
  } pwm_exp_t;

  int       exp_duty_q[$];
  pwm_exp_t pwm_q[$];
  int       base = 0;
  int       seg = 0;
  bit       started = 1'b0;
  int       n_chk = 0;
  int       n_pass = 0;
  int       last_tick = -100;
  int       highs = 0;

  task automatic check(string name, longint act, longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d",
                  name, act, exp, cyc - base);
  endtask

  task automatic at(int n);
    forever begin
      @(negedge clk_in);
      if (cyc - base == n) break;
      if (cyc - base > n) begin
        $display("FAIL timeline: passed cycle %0d", n);
        $fatal(1, "timeline overrun");
      end
    end
  endtask

  task automatic push_pwm(int per, int h);
    pwm_exp_t e;
    e.per   = per;
    e.highs = h;
    pwm_q.push_back(e);
  endtask

  // Monitor: strobe scoreboard and per-period PWM high-time.
  always @(negedge clk_in) begin
    if (started) begin
      int r;
      int s;
      int pc;
      int e;
      pwm_exp_t pe;
      r = cyc - base;
      s = r - seg;
      if (s >= 0 && s % SC == SC - 1) last_tick = r;
      if (update_done_out) begin
        if (exp_duty_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_strobe at cycle %0d duty %0d", r, duty_out);
        end else begin
          e = exp_duty_q.pop_front();
          check("strobe_duty", duty_out, e);
          check("strobe_latency", r - last_tick, 5);
        end
      end
      if (s >= 0) begin
        pc = s % 1024;
        if (pc == 0) highs = 0;
        if (pwm_out) highs++;
        if (pc == 1023 && pwm_q.size() > 0 && pwm_q[0].per == s / 1024) begin
          pe = pwm_q.pop_front();
          check("pwm_high_cycles", highs, pe.highs);
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk_in);
    reset_in      = 1'b0;
    enable_in     = 1'b1;
    target_rpm_in = 21'd300;
    actual_rpm_in = 21'd0;
    base          = cyc;
    seg           = 0;
    started       = 1'b1;
    check("reset_duty", duty_out, 0);
    check("reset_pwm", pwm_out, 0);
    check("reset_strobe", update_done_out, 0);
    check("reset_integ", dut.integ_q, 0);

    // step response and glitch-free reload 93 -> 112
    exp_duty_q.push_back(93);
    exp_duty_q.push_back(112);
    exp_duty_q.push_back(131);
    push_pwm(0, 0);
    push_pwm(1, 93);
    push_pwm(2, 112);
    at(2100);
    check("step_integ", dut.integ_q, 600);

    // negative error from a cleared integrator
    at(3100);
    enable_in = 1'b0;
    at(3101);
    check("dis_integ", dut.integ_q, 0);
    check("dis_duty", duty_out, 0);
    check("dis_pwm", pwm_out, 0);
    enable_in     = 1'b1;
    target_rpm_in = 21'd0;
    actual_rpm_in = 21'd300;
    exp_duty_q.push_back(0);
    push_pwm(4, 0);
    at(4010);
    check("neg_integ", dut.integ_q, -300);
    check("neg_duty", duty_out, 0);

    // saturation and integrator clamp
    target_rpm_in = 21'd2_000_000;
    actual_rpm_in = 21'd0;
    repeat (3) exp_duty_q.push_back(1023);
    push_pwm(5, 1023);
    at(5010);
    check("clamp_integ_1", dut.integ_q, 1_048_576);
    at(6010);
    check("clamp_integ_2", dut.integ_q, 1_048_576);
    at(7010);
    check("clamp_integ_3", dut.integ_q, 1_048_576);

    // enable drop during MULT (tick 7999 -> MULT at 8002)
    at(8002);
    enable_in = 1'b0;
    at(8003);
    check("drop_integ", dut.integ_q, 0);
    check("drop_duty", duty_out, 0);
    enable_in     = 1'b1;
    target_rpm_in = 21'd300;
    actual_rpm_in = 21'd0;
    exp_duty_q.push_back(93);
    at(9010);
    check("recompute_integ", dut.integ_q, 300);
    check("recompute_duty", duty_out, 93);

    // reset during SUM (tick 9999 -> SUM at 10003)
    at(10003);
    reset_in = 1'b1;
    at(10004);
    reset_in = 1'b0;
    seg      = 10004;
    check("rst_duty", duty_out, 0);
    check("rst_pwm", pwm_out, 0);
    check("rst_strobe", update_done_out, 0);
    check("rst_integ", dut.integ_q, 0);
    exp_duty_q.push_back(93);
    at(10500);
    check("rst_duty_hold", duty_out, 0);
    at(11020);
    check("strobes_pending", exp_duty_q.size(), 0);
    check("pwm_pending", pwm_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
